// File: rtl/default_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : default_slave_pkg
//  Description : Shared AXI definitions: channel widths and response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package default_slave_pkg;

    localparam int unsigned AXI_ID_W    = 8;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_LEN_W   = 4;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;
    localparam int unsigned AXI_STRB_W  = AXI_DATA_W / 8;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage : default_slave_pkg
`default_nettype wire

// File: rtl/default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : default_slave
//  Description : AXI default slave for unmapped address space. Accepts every
//                write and read burst and answers it with DECERR. Write and
//                read paths are two independent FSMs; the read path has a
//                beat counter so exactly ARLEN+1 beats are returned.
//  Revision    : 1.0 - initial release
// ============================================================================
module default_slave
    import default_slave_pkg::*;
(
    input  logic                     ACLK,
    input  logic                     ARESETn,
    // Write address channel
    input  logic [AXI_ID_W-1:0]      AWID,
    input  logic [AXI_ADDR_W-1:0]    AWADDR,
    input  logic [AXI_LEN_W-1:0]     AWLEN,
    input  logic [AXI_SIZE_W-1:0]    AWSIZE,
    input  logic [AXI_BURST_W-1:0]   AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    // Write data channel
    input  logic [AXI_DATA_W-1:0]    WDATA,
    input  logic [AXI_STRB_W-1:0]    WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    // Write response channel
    output logic [AXI_ID_W-1:0]      BID,
    output logic [AXI_RESP_W-1:0]    BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    // Read address channel
    input  logic [AXI_ID_W-1:0]      ARID,
    input  logic [AXI_ADDR_W-1:0]    ARADDR,
    input  logic [AXI_LEN_W-1:0]     ARLEN,
    input  logic [AXI_SIZE_W-1:0]    ARSIZE,
    input  logic [AXI_BURST_W-1:0]   ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    // Read data channel
    output logic [AXI_ID_W-1:0]      RID,
    output logic [AXI_DATA_W-1:0]    RDATA,
    output logic [AXI_RESP_W-1:0]    RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Write path state and registered outputs
    // ------------------------------------------------------------------
    wstate_t                 r_wstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [AXI_ID_W-1:0]     r_bid;
    logic [AXI_RESP_W-1:0]   r_bresp;

    // ------------------------------------------------------------------
    // Read path state, beat counter and registered outputs
    // ------------------------------------------------------------------
    rstate_t                 r_rstate;
    logic                    r_arready;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [AXI_ID_W-1:0]     r_rid;
    logic [AXI_RESP_W-1:0]   r_rresp;
    logic [AXI_LEN_W-1:0]    r_rlen;
    logic [AXI_LEN_W-1:0]    r_rcnt;

    // Address attributes and write payload are irrelevant to an error slave.
    logic                    w_unused;
    assign w_unused = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                        ARADDR, ARSIZE, ARBURST};

    // Write FSM: accept AW, sink W beats until WLAST, then hold a DECERR B.
    // READY/VALID are registered so no input reaches an output combinationally;
    // AWREADY stays low during reset and rises on the first cycle after release.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (AWVALID && r_awready) begin
                        r_bid     <= AWID;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && r_wready && WLAST) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_DECERR;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_bresp   <= RESP_OKAY;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, then stream ARLEN+1 zero-data DECERR beats.
    // RLAST is precomputed one cycle ahead so it is a pure register; the
    // counter stops on the last beat so ARLEN=15 never wraps.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlen    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (ARVALID && r_arready) begin
                        r_rid     <= ARID;
                        r_rlen    <= ARLEN;
                        r_rcnt    <= '0;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= RESP_DECERR;
                        r_rlast   <= (ARLEN == '0);
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= RESP_OKAY;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 4'd1;
                            r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_rresp   <= RESP_OKAY;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BID     = r_bid;
    assign BRESP   = r_bresp;

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rlast;
    assign RID     = r_rid;
    assign RRESP   = r_rresp;
    assign RDATA   = '0;

endmodule : default_slave
`default_nettype wire

// File: tb/tb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_default_slave
//  Description : Directed self-checking bench for the AXI default slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_default_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    default_slave u_dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWSIZE  (AWSIZE),
        .AWBURST (AWBURST),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARSIZE  (ARSIZE),
        .ARBURST (ARBURST),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Read-channel snapshot check for one beat.
    task automatic chk_rbeat(input string tag, input logic [7:0] id, input logic last);
        chk({tag, ".rvalid"}, {31'd0, RVALID}, 32'd1);
        chk({tag, ".rid"},    {24'd0, RID},    {24'd0, id});
        chk({tag, ".rdata"},  RDATA,           32'd0);
        chk({tag, ".rresp"},  {30'd0, RRESP},  32'd3);
        chk({tag, ".rlast"},  {31'd0, RLAST},  {31'd0, last});
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        // ---------------- reset values ----------------
        tick(); tick();
        chk("rst.awready", {31'd0, AWREADY}, 32'd0);
        chk("rst.wready",  {31'd0, WREADY},  32'd0);
        chk("rst.bvalid",  {31'd0, BVALID},  32'd0);
        chk("rst.arready", {31'd0, ARREADY}, 32'd0);
        chk("rst.rvalid",  {31'd0, RVALID},  32'd0);
        chk("rst.rlast",   {31'd0, RLAST},   32'd0);
        chk("rst.bid",     {24'd0, BID},     32'd0);
        chk("rst.rid",     {24'd0, RID},     32'd0);
        chk("rst.bresp",   {30'd0, BRESP},   32'd0);
        chk("rst.rresp",   {30'd0, RRESP},   32'd0);
        chk("rst.rdata",   RDATA,            32'd0);
        ARESETn = 1'b1;
        tick();
        chk("rel.awready", {31'd0, AWREADY}, 32'd1);
        chk("rel.arready", {31'd0, ARREADY}, 32'd1);

        // ---------------- W beat while idle is refused ----------------
        WVALID = 1'b1; WLAST = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        chk("widle.wready", {31'd0, WREADY}, 32'd0);
        tick();
        chk("widle.bvalid",  {31'd0, BVALID},  32'd0);
        chk("widle.awready", {31'd0, AWREADY}, 32'd1);
        WVALID = 1'b0; WLAST = 1'b0;

        // ---------------- 4-beat write, ID 0x25 ----------------
        AWID = 8'h25; AWADDR = 32'h0004_0000; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("wr.awready_busy", {31'd0, AWREADY}, 32'd0);
        BREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WVALID = 1'b1; WLAST = (i == 3); WDATA = 32'h1000 + i;
            chk($sformatf("wr.wready%0d", i), {31'd0, WREADY}, 32'd1);
            chk($sformatf("wr.bvalid_early%0d", i), {31'd0, BVALID}, 32'd0);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("wr.wready_done", {31'd0, WREADY}, 32'd0);
        chk("wr.bvalid",      {31'd0, BVALID}, 32'd1);
        chk("wr.bid",         {24'd0, BID},    32'h25);
        chk("wr.bresp",       {30'd0, BRESP},  32'd3);
        tick();
        chk("wr.bvalid_drop", {31'd0, BVALID},  32'd0);
        chk("wr.awready_ret", {31'd0, AWREADY}, 32'd1);
        BREADY = 1'b0;

        // ---------------- 4-beat read, ID 0x13 ----------------
        ARID = 8'h13; ARLEN = 4'd3; ARADDR = 32'h0002_0000; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        chk("rd.arready_busy", {31'd0, ARREADY}, 32'd0);
        RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rbeat($sformatf("rd.b%0d", i), 8'h13, (i == 3));
            tick();
        end
        chk("rd.rvalid_done", {31'd0, RVALID},  32'd0);
        chk("rd.arready_ret", {31'd0, ARREADY}, 32'd1);
        RREADY = 1'b0;

        // ---------------- 16-beat read with RREADY toggling ----------------
        ARID = 8'h6B; ARLEN = 4'hF; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        for (int b = 0; b < 16; b++) begin
            RREADY = 1'b0;
            chk_rbeat($sformatf("r16.stall%0d", b), 8'h6B, (b == 15));
            tick();
            RREADY = 1'b1;
            chk_rbeat($sformatf("r16.beat%0d", b), 8'h6B, (b == 15));
            tick();
        end
        RREADY = 1'b0;
        chk("r16.rvalid_done", {31'd0, RVALID},  32'd0);
        chk("r16.arready_ret", {31'd0, ARREADY}, 32'd1);

        // ---------------- simultaneous AW and AR ----------------
        AWID = 8'h5A; AWVALID = 1'b1;
        ARID = 8'hA5; ARLEN = 4'd1; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("both.awready", {31'd0, AWREADY}, 32'd0);
        chk("both.arready", {31'd0, ARREADY}, 32'd0);
        chk("both.wready",  {31'd0, WREADY},  32'd1);
        chk_rbeat("both.r0", 8'hA5, 1'b0);
        WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        chk("both.bvalid", {31'd0, BVALID}, 32'd1);
        chk("both.bid",    {24'd0, BID},    32'h5A);
        chk("both.bresp",  {30'd0, BRESP},  32'd3);
        chk_rbeat("both.r1", 8'hA5, 1'b1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        chk("both.bvalid_done", {31'd0, BVALID}, 32'd0);
        chk("both.rvalid_done", {31'd0, RVALID}, 32'd0);
        chk("both.awready_ret", {31'd0, AWREADY}, 32'd1);
        chk("both.arready_ret", {31'd0, ARREADY}, 32'd1);

        // ---------------- BREADY held low for 5 cycles ----------------
        AWID = 8'h77; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b1; WLAST = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bhold.bvalid%0d", i),  {31'd0, BVALID},  32'd1);
            chk($sformatf("bhold.bid%0d", i),     {24'd0, BID},     32'h77);
            chk($sformatf("bhold.awready%0d", i), {31'd0, AWREADY}, 32'd0);
            tick();
        end
        BREADY = 1'b1;
        chk("bhold.bvalid_last", {31'd0, BVALID}, 32'd1);
        tick();
        BREADY = 1'b0;
        chk("bhold.bvalid_done", {31'd0, BVALID},  32'd0);
        chk("bhold.awready_ret", {31'd0, AWREADY}, 32'd1);

        // ---------------- reset during read beat 2 of ARLEN=7 ----------------
        ARID = 8'h3C; ARLEN = 4'd7; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        chk_rbeat("rrst.b0", 8'h3C, 1'b0);
        tick();
        chk_rbeat("rrst.b1", 8'h3C, 1'b0);
        ARESETn = 1'b0;
        tick();
        chk("rrst.rvalid_rst",  {31'd0, RVALID},  32'd0);
        chk("rrst.arready_rst", {31'd0, ARREADY}, 32'd0);
        chk("rrst.rid_rst",     {24'd0, RID},     32'd0);
        ARESETn = 1'b1;
        tick();
        chk("rrst.arready_rel", {31'd0, ARREADY}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rrst.no_beat%0d", i), {31'd0, RVALID}, 32'd0);
            chk($sformatf("rrst.no_b%0d", i),    {31'd0, BVALID}, 32'd0);
            tick();
        end
        RREADY = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_default_slave
`default_nettype wire
